// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: datapath width and op encodings.
package stack_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_NOP   = 3'd0;
    localparam op_t OP_PUSH  = 3'd1;
    localparam op_t OP_POP   = 3'd2;
    localparam op_t OP_DUP   = 3'd3;
    localparam op_t OP_SWAP  = 3'd4;
    localparam op_t OP_BINOP = 3'd5;
    localparam op_t OP_REPL  = 3'd6;
    localparam op_t OP_RSVD  = 3'd7;

endpackage

// File: rtl/stack_spill_ram.sv
// Spill storage below NOS: synchronous write, asynchronous read, no reset
// (contents are unreachable until written because depth gates every read).
module stack_spill_ram #(
    parameter int DATA_W  = 16,
    parameter int ENTRIES = 14,
    parameter int AW      = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [ENTRIES];

    // Spill write: NOS is pushed down into the array on a growing op.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/operand_stack.sv
// Operand stack with registered TOS/NOS feeding the ALU, a spill array below
// NOS, legality decode for every op, and sticky overflow/underflow flags.
module operand_stack #(
    parameter int DATA_W = stack_pkg::DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       op_valid,
    input  logic [stack_pkg::OP_W-1:0] op,
    input  logic [DATA_W-1:0]          din,
    input  logic                       err_clr,
    output logic [DATA_W-1:0]          tos,
    output logic [DATA_W-1:0]          nos,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf
);

    import stack_pkg::*;

    localparam int DW      = $clog2(DEPTH+1);
    localparam int ENTRIES = DEPTH - 2;
    localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    localparam logic [DW-1:0] D_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] D1    = DW'(1);
    localparam logic [DW-1:0] D2    = DW'(2);
    localparam logic [DW-1:0] D3    = DW'(3);

    logic [DATA_W-1:0] tos_q, tos_d;
    logic [DATA_W-1:0] nos_q, nos_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              empty_q, full_q;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              ovf_ev, unf_ev;

    logic              has1, has2, has3, room;
    logic              spill_we;
    logic [AW-1:0]     spill_waddr, spill_raddr;
    logic [DATA_W-1:0] spill_rdata, refill;

    assign has1 = (depth_q >= D1);
    assign has2 = (depth_q >= D2);
    assign has3 = (depth_q >= D3);
    assign room = (depth_q <  D_MAX);

    // Array addressing: spill lands at depth-2, refill comes from depth-3.
    always_comb begin
        spill_waddr = '0;
        spill_raddr = '0;
        if (has2) spill_waddr = AW'(depth_q - D2);
        if (has3) spill_raddr = AW'(depth_q - D3);
    end

    // With fewer than three entries nothing sits below NOS, so refill is zero.
    assign refill = has3 ? spill_rdata : '0;

    stack_spill_ram #(
        .DATA_W  (DATA_W),
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_spill (
        .clk_i   (CLK),
        .we_i    (spill_we),
        .waddr_i (spill_waddr),
        .wdata_i (nos_q),
        .raddr_i (spill_raddr),
        .rdata_o (spill_rdata)
    );

    // Legality decode and next-state for the op; illegal ops only raise a flag.
    always_comb begin
        tos_d    = tos_q;
        nos_d    = nos_q;
        depth_d  = depth_q;
        spill_we = 1'b0;
        ovf_ev   = 1'b0;
        unf_ev   = 1'b0;
        if (op_valid) begin
            case (op)
                OP_PUSH: begin
                    if (room) begin
                        tos_d    = din;
                        nos_d    = tos_q;
                        spill_we = has2;
                        depth_d  = depth_q + D1;
                    end else begin
                        ovf_ev = 1'b1;
                    end
                end
                OP_POP: begin
                    if (has1) begin
                        tos_d   = nos_q;
                        nos_d   = refill;
                        depth_d = depth_q - D1;
                    end else begin
                        unf_ev = 1'b1;
                    end
                end
                OP_DUP: begin
                    if (!has1) begin
                        unf_ev = 1'b1;
                    end else if (!room) begin
                        ovf_ev = 1'b1;
                    end else begin
                        nos_d    = tos_q;
                        spill_we = has2;
                        depth_d  = depth_q + D1;
                    end
                end
                OP_SWAP: begin
                    if (has2) begin
                        tos_d = nos_q;
                        nos_d = tos_q;
                    end else begin
                        unf_ev = 1'b1;
                    end
                end
                OP_BINOP: begin
                    if (has2) begin
                        tos_d   = din;
                        nos_d   = refill;
                        depth_d = depth_q - D1;
                    end else begin
                        unf_ev = 1'b1;
                    end
                end
                OP_REPL: begin
                    if (has1) begin
                        tos_d = din;
                    end else begin
                        unf_ev = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
        // A new error in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_ev | (ovf_q & ~err_clr);
        unf_d = unf_ev | (unf_q & ~err_clr);
    end

    // State registers; status outputs are registered from the next depth.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tos_q   <= '0;
            nos_q   <= '0;
            depth_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            depth_q <= depth_d;
            empty_q <= (depth_d == '0);
            full_q  <= (depth_d == D_MAX);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign tos   = tos_q;
    assign nos   = nos_q;
    assign depth = depth_q;
    assign empty = empty_q;
    assign full  = full_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: queue-based reference model checked every cycle,
// plus literal expectations from hand-worked sequences.
module tb_operand_stack;

    localparam int DEPTH = 16;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] PUSH  = 3'd1;
    localparam logic [2:0] POP   = 3'd2;
    localparam logic [2:0] DUP   = 3'd3;
    localparam logic [2:0] SWAP  = 3'd4;
    localparam logic [2:0] BINOP = 3'd5;
    localparam logic [2:0] REPL  = 3'd6;
    localparam logic [2:0] RSVD  = 3'd7;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] din = 16'h0;
    logic        err_clr = 1'b0;
    logic [15:0] tos, nos;
    logic [4:0]  depth;
    logic        empty, full, ovf, unf;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [15:0] mstk[$];
    bit          movf = 1'b0;
    bit          munf = 1'b0;

    operand_stack #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .din      (din),
        .err_clr  (err_clr),
        .tos      (tos),
        .nos      (nos),
        .depth    (depth),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .unf      (unf)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_tos();
        return (mstk.size() > 0) ? mstk[mstk.size()-1] : 16'h0;
    endfunction

    function automatic logic [15:0] m_nos();
        return (mstk.size() > 1) ? mstk[mstk.size()-2] : 16'h0;
    endfunction

    // Reference behaviour of one executed op on the model stack.
    task automatic model_op(input logic [2:0] o, input logic [15:0] d, input logic v, input logic c);
        logic [15:0] a, b;
        int n;
        n = mstk.size();
        if (c) begin
            movf = 1'b0;
            munf = 1'b0;
        end
        if (v) begin
            case (o)
                PUSH:  if (n < DEPTH) mstk.push_back(d); else movf = 1'b1;
                POP:   if (n >= 1) void'(mstk.pop_back()); else munf = 1'b1;
                DUP:   if (n == 0) munf = 1'b1;
                       else if (n == DEPTH) movf = 1'b1;
                       else mstk.push_back(mstk[n-1]);
                SWAP:  if (n >= 2) begin
                           a = mstk[n-1]; b = mstk[n-2];
                           mstk[n-1] = b; mstk[n-2] = a;
                       end else munf = 1'b1;
                BINOP: if (n >= 2) begin
                           void'(mstk.pop_back()); void'(mstk.pop_back());
                           mstk.push_back(d);
                       end else munf = 1'b1;
                REPL:  if (n >= 1) mstk[n-1] = d; else munf = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [15:0] d,
                         input logic v = 1'b1, input logic c = 1'b0);
        @(negedge CLK);
        op = o; din = d; op_valid = v; err_clr = c;
        @(posedge CLK);
        model_op(o, d, v, c);
        #1;
        op_valid = 1'b0; err_clr = 1'b0; op = NOP; din = 16'h0;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        #1;
        reset = 1'b0;
        mstk.delete();
        movf = 1'b0;
        munf = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    // Every cycle, outputs must match the model's view of the stack.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("tos",   {16'h0, tos},   {16'h0, m_tos()});
            check("nos",   {16'h0, nos},   {16'h0, m_nos()});
            check("depth", {27'h0, depth}, mstk.size());
            check("empty", {31'h0, empty}, {31'h0, mstk.size() == 0});
            check("full",  {31'h0, full},  {31'h0, mstk.size() == DEPTH});
            check("ovf",   {31'h0, ovf},   {31'h0, movf});
            check("unf",   {31'h0, unf},   {31'h0, munf});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        #1;
        check("rst_tos",   {16'h0, tos}, 32'h0);
        check("rst_depth", {27'h0, depth}, 32'h0);
        check("rst_empty", {31'h0, empty}, 32'h1);
        check("rst_flags", {30'h0, ovf, unf}, 32'h0);
        #10 reset = 1'b1;
        chk_en = 1'b1;

        // Two pushes
        do_op(PUSH, 16'h00F0);
        do_op(PUSH, 16'h10F0);
        check("p2_tos",   {16'h0, tos}, 32'h10F0);
        check("p2_nos",   {16'h0, nos}, 32'h00F0);
        check("p2_depth", {27'h0, depth}, 32'd2);
        check("p2_empty", {31'h0, empty}, 32'h0);

        // BINOP then SWAP
        pulse_reset();
        do_op(PUSH, 16'd1); do_op(PUSH, 16'd2); do_op(PUSH, 16'd3);
        do_op(BINOP, 16'h0005);
        check("bin_tos",   {16'h0, tos}, 32'h5);
        check("bin_nos",   {16'h0, nos}, 32'h1);
        check("bin_depth", {27'h0, depth}, 32'd2);
        do_op(SWAP, 16'h0);
        check("swp_tos", {16'h0, tos}, 32'h1);
        check("swp_nos", {16'h0, nos}, 32'h5);

        // Fill, overflow, drain
        pulse_reset();
        for (int i = 0; i < 16; i++) do_op(PUSH, 16'(i));
        do_op(PUSH, 16'h8888);
        check("ovf_flag",  {31'h0, ovf}, 32'h1);
        check("ovf_full",  {31'h0, full}, 32'h1);
        check("ovf_tos",   {16'h0, tos}, 32'd15);
        check("ovf_depth", {27'h0, depth}, 32'd16);
        do_op(DUP, 16'h0);
        check("dup_full_depth", {27'h0, depth}, 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("drain_tos", {16'h0, tos}, 32'(15 - i));
            do_op(POP, 16'h0);
        end
        check("drain_empty", {31'h0, empty}, 32'h1);

        // Underflow and sticky clear
        pulse_reset();
        do_op(POP, 16'h0);
        do_op(SWAP, 16'h0);
        check("unf_flag",  {31'h0, unf}, 32'h1);
        check("unf_depth", {27'h0, depth}, 32'h0);
        check("unf_tosnos", {tos, nos}, 32'h0);
        do_op(NOP, 16'h0, 1'b0, 1'b1);
        check("clr_unf", {31'h0, unf}, 32'h0);
        do_op(POP, 16'h0, 1'b1, 1'b1);
        check("clr_vs_new", {31'h0, unf}, 32'h1);
        do_op(REPL, 16'h1111);
        do_op(BINOP, 16'h2222);

        // DUP and REPL at shallow depth
        pulse_reset();
        do_op(PUSH, 16'h1234);
        do_op(BINOP, 16'h9999);
        do_op(DUP, 16'h0);
        check("dup_tos", {16'h0, tos}, 32'h1234);
        check("dup_nos", {16'h0, nos}, 32'h1234);
        do_op(REPL, 16'hBEEF);
        check("repl_tos", {16'h0, tos}, 32'hBEEF);
        check("repl_nos", {16'h0, nos}, 32'h1234);

        // Gated and reserved ops, then a deep mixed sequence through the array
        do_op(PUSH, 16'hAAAA, 1'b0);
        do_op(RSVD, 16'hBBBB);
        for (int i = 0; i < 10; i++) do_op(PUSH, 16'h0100 + 16'(i));
        do_op(BINOP, 16'h5A5A);
        do_op(SWAP, 16'h0);
        do_op(DUP, 16'h0);
        do_op(POP, 16'h0); do_op(POP, 16'h0); do_op(POP, 16'h0);
        do_op(BINOP, 16'hC3C3);
        do_op(PUSH, 16'h7777);
        for (int i = 0; i < 6; i++) do_op(POP, 16'h0);

        // Asynchronous reset mid-stream
        pulse_reset();
        for (int i = 0; i < 5; i++) do_op(PUSH, 16'h0040 + 16'(i));
        check("pre_rst_depth", {27'h0, depth}, 32'd5);
        #2;
        reset = 1'b0;
        mstk.delete();
        movf = 1'b0;
        munf = 1'b0;
        #1;
        check("arst_tosnos", {tos, nos}, 32'h0);
        check("arst_depth",  {27'h0, depth}, 32'h0);
        check("arst_empty",  {31'h0, empty}, 32'h1);
        check("arst_flags",  {30'h0, full, ovf}, 32'h0);
        @(negedge CLK);
        #2 reset = 1'b1;
        do_op(PUSH, 16'd7);
        check("post_tos",   {16'h0, tos}, 32'h7);
        check("post_nos",   {16'h0, nos}, 32'h0);
        check("post_depth", {27'h0, depth}, 32'd1);

        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/operand_stack.md
# operand_stack

Hardware operand stack for the 16-bit stack processor, upstream of the ALU/ALUOut/memory stage. Holds the evaluation stack, presents top-of-stack and next-of-stack as registered outputs that drive the ALU `Avalue`/`Bvalue` operands, and accepts the stage's result (ALUOut or memory read data) for write-back. One stack operation is executed per clock. Over- and underflow are detected, suppressed, and reported through sticky flags.

## Interface
Parameters:
- `DATA_W`, 16: word width; matches the datapath.
- `DEPTH`, 16: maximum number of entries, at least 3; `DEPTH`−2 entries live in the spill array.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; asserting it (0) clears all state immediately.
- `op_valid` in 1: executes `op` this cycle when 1.
- `op` in 3: operation code (encodings under Operation).
- `din` in DATA_W: push/result data.
- `err_clr` in 1: clears the sticky error flags.
- `tos` out DATA_W: top of stack (ALU `Avalue`).
- `nos` out DATA_W: next of stack (ALU `Bvalue`).
- `depth` out $clog2(DEPTH+1): current entry count.
- `empty` out 1: `depth`==0.
- `full` out 1: `depth`==`DEPTH`.
- `ovf` out 1: sticky overflow.
- `unf` out 1: sticky underflow.

## Operation
Op encodings:
- 0 NOP.
- 1 PUSH: `din` becomes TOS.
- 2 POP: discard TOS.
- 3 DUP: copy TOS.
- 4 SWAP: exchange TOS and NOS.
- 5 BINOP: pop two, push `din`; net −1.
- 6 REPL: TOS←`din`; depth unchanged.
- 7: reserved, treated as NOP.

Required depth, per op:
- PUSH: depth < DEPTH, else overflow.
- DUP: 1 ≤ depth < DEPTH. If depth is 0 it is an underflow; if depth is DEPTH it is an overflow.
- POP: depth ≥ 1, else underflow.
- REPL: depth ≥ 1, else underflow.
- SWAP: depth ≥ 2, else underflow.
- BINOP: depth ≥ 2, else underflow.

Behaviour:
- A failing op changes no stack state or depth. It sets `ovf` or `unf`.
- Flags are sticky until `err_clr`=1. If `err_clr` and a new error occur in the same cycle, the new error wins and the flag stays 1.
- Storage: TOS register, NOS register, and the spill array below NOS. A push moves NOS into the array and TOS into NOS. A pop refills NOS from the array.
- Invalid positions read as 0: `tos`=0 when depth=0, and `nos`=0 when depth<2. Vacated registers are zeroed.
- `op_valid`=0 means no state change regardless of `op`.

## Timing
- `tos`, `nos`, `depth`, `empty`, `full`, `ovf` and `unf` are all registered.
- The result of an op executed at edge N is visible right after edge N, so back-to-back ops every cycle are supported.
- `din` is sampled at the edge. BINOP uses the ALU result computed from the current `tos`/`nos` in the same cycle, so the ALU path is combinational within that cycle.
- Asynchronous reset values: all outputs 0 except `empty`=1. The array contents need not be cleared; they are unreachable because depth is 0.
- Reset mid-stream discards the op in flight. The first op after release sees an empty stack.
- Wrap-around: not allowed. Depth saturates by the rules above and never rolls over.
- The array is read at index depth−3 (refill on pop) and written at index depth−2 (spill on push). Both accesses complete in one cycle.

## Structure
- Package `stack_pkg` holds the op encoding localparams (`OP_NOP` … `OP_REPL`) and `DATA_W`.
- Sub-module `stack_spill_ram` is a parameterised synchronous-write, asynchronous-read array of `DEPTH`−2 × `DATA_W`.
- The top level holds the TOS/NOS registers, the depth counter, the legality decode and the flags.

## Test plan
- Reset then PUSH 0x00F0, PUSH 0x10F0: `tos`=0x10F0, `nos`=0x00F0, `depth`=2, `empty`=0.
- PUSH 1, 2 and 3, then BINOP with `din`=0x0005: `tos`=0x0005, `nos`=1, `depth`=2. Then SWAP: `tos`=1, `nos`=5.
- Fill to `DEPTH`=16 with 0..15, then PUSH 0x8888: `ovf`=1, `full`=1, `tos`=15, `depth` stays 16. Then POP 16 times: the values come off in reverse order and `empty`=1.
- On an empty stack, POP then SWAP: `unf`=1, `depth`=0, `tos`=`nos`=0. Then `err_clr`: `unf`=0. `err_clr` together with a POP on an empty stack: `unf` stays 1.
- DUP at depth 1 (`tos`=0x1234): `tos`=`nos`=0x1234. REPL with `din`=0xBEEF: `tos`=0xBEEF, `nos`=0x1234.
- Drive `reset`=0 mid-sequence at depth 5 between clock edges: all outputs drop to reset values immediately. After release, PUSH 7 gives `tos`=7, `nos`=0, `depth`=1.
